// File: rtl/pad_cfg_ctrl.sv
// pad_cfg_ctrl: register-mapped pad configuration controller.
// Each pad has a shadow config (written by cfg requests) and an active
// config (drives the pad controls). Writing address 63 (COMMIT) copies every
// shadow entry to active in a single edge so all pads switch together.
// Optional macro PAD_CFG_SYNC_EN: when defined, input_sync/bidir_sync are
// two-flop synchronized copies of the pad inputs; otherwise they are direct
// combinational pass-throughs.
//
// Handshake: a request transfers on a rising edge where cfg_valid && cfg_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. Only one
// request is outstanding; cfg_ready is low while a response is pending, and
// rsp_rdata/rsp_err hold steady until the response handshake.
module pad_cfg_ctrl #(
    parameter int NUM_INPUT_PADS = 12,
    parameter int NUM_BIDIR_PADS = 40
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic                      cfg_we,
    input  logic [5:0]                cfg_addr,
    input  logic [5:0]                cfg_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [5:0]                rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_INPUT_PADS-1:0] input_pu,
    output logic [NUM_INPUT_PADS-1:0] input_pd,
    output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
    output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
    output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
    output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
    input  logic [NUM_INPUT_PADS-1:0] input_in,
    input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
    output logic [NUM_INPUT_PADS-1:0] input_sync,
    output logic [NUM_BIDIR_PADS-1:0] bidir_sync
);

    localparam int NI = NUM_INPUT_PADS;
    localparam int NB = NUM_BIDIR_PADS;
    localparam int IW = (NI > 1) ? $clog2(NI) : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    // Bit layout {pd,pu,ie,sl,cs,oe}; bidir pads come out of reset input-enabled.
    localparam logic [5:0] BIDIR_RESET = 6'b001000;
    localparam logic [5:0] ADDR_COMMIT = 6'd63;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Bidir entries hold all six bits; input entries hold only {pd,pu}.
    logic [5:0] bidir_shadow [NB];
    logic [5:0] bidir_active [NB];
    logic [1:0] input_shadow [NI];
    logic [1:0] input_active [NI];

    logic          accept;
    logic          is_bidir, is_input, is_commit;
    logic [BW-1:0] bidir_idx;
    logic [IW-1:0] input_idx;
    logic          pupd_conflict;
    logic          dirty;
    logic          bidir_wr, input_wr, commit_en;
    logic [5:0]    rdata_d, rdata_q;
    logic          err_d, err_q;

    assign accept = cfg_valid & cfg_ready;

    // Address decode and write-data sanity (pull-up and pull-down together is illegal).
    always_comb begin
        is_bidir      = cfg_addr < 6'(NB);
        is_input      = (cfg_addr >= 6'(NB)) && (cfg_addr < 6'(NB + NI));
        is_commit     = cfg_addr == ADDR_COMMIT;
        bidir_idx     = cfg_addr[BW-1:0];
        input_idx     = IW'(cfg_addr - 6'(NB));
        pupd_conflict = cfg_wdata[5] & cfg_wdata[4];
    end

    // Any shadow entry that differs from its active entry means a commit is pending.
    always_comb begin
        dirty = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (bidir_shadow[i] != bidir_active[i]) dirty = 1'b1;
        end
        for (int i = 0; i < NI; i++) begin
            if (input_shadow[i] != input_active[i]) dirty = 1'b1;
        end
    end

    // Request decode: response payload and which state update the request implies.
    always_comb begin
        rdata_d   = 6'd0;
        err_d     = 1'b0;
        bidir_wr  = 1'b0;
        input_wr  = 1'b0;
        commit_en = 1'b0;
        if (is_commit) begin
            if (cfg_we) commit_en = 1'b1;
            else        rdata_d   = {5'd0, dirty};
        end else if (is_bidir) begin
            if (cfg_we) begin
                if (pupd_conflict) err_d    = 1'b1;
                else               bidir_wr = 1'b1;
            end else begin
                rdata_d = bidir_shadow[bidir_idx];
            end
        end else if (is_input) begin
            if (cfg_we) begin
                if (pupd_conflict) err_d    = 1'b1;
                else               input_wr = 1'b1;
            end else begin
                rdata_d = {input_shadow[input_idx], 4'd0};
            end
        end else begin
            err_d = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Response payload captured at acceptance and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 6'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_rdata = rsp_valid ? rdata_q : 6'd0;
    assign rsp_err   = rsp_valid ? err_q : 1'b0;

    // Shadow writes and whole-array commit into active config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                bidir_shadow[i] <= BIDIR_RESET;
                bidir_active[i] <= BIDIR_RESET;
            end
            for (int i = 0; i < NI; i++) begin
                input_shadow[i] <= 2'b00;
                input_active[i] <= 2'b00;
            end
        end else if (accept) begin
            if (bidir_wr) bidir_shadow[bidir_idx] <= cfg_wdata;
            if (input_wr) input_shadow[input_idx] <= cfg_wdata[5:4];
            if (commit_en) begin
                for (int i = 0; i < NB; i++) bidir_active[i] <= bidir_shadow[i];
                for (int i = 0; i < NI; i++) input_active[i] <= input_shadow[i];
            end
        end
    end

    // Pad controls come only from the active config.
    for (genvar g = 0; g < NB; g++) begin : g_bidir
        assign bidir_oe[g] = bidir_active[g][0];
        assign bidir_cs[g] = bidir_active[g][1];
        assign bidir_sl[g] = bidir_active[g][2];
        assign bidir_ie[g] = bidir_active[g][3];
        assign bidir_pu[g] = bidir_active[g][4];
        assign bidir_pd[g] = bidir_active[g][5];
    end
    for (genvar g = 0; g < NI; g++) begin : g_input
        assign input_pu[g] = input_active[g][0];
        assign input_pd[g] = input_active[g][1];
    end

`ifdef PAD_CFG_SYNC_EN
    logic [NI-1:0] input_meta, input_q;
    logic [NB-1:0] bidir_meta, bidir_q;

    // Two-flop synchronizers for asynchronous pad inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            input_meta <= '0;
            input_q    <= '0;
            bidir_meta <= '0;
            bidir_q    <= '0;
        end else begin
            input_meta <= input_in;
            input_q    <= input_meta;
            bidir_meta <= bidir_in;
            bidir_q    <= bidir_meta;
        end
    end

    assign input_sync = input_q;
    assign bidir_sync = bidir_q;
`else
    assign input_sync = input_in;
    assign bidir_sync = bidir_in;
`endif

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// tb_pad_cfg_ctrl: directed bench for pad_cfg_ctrl with hand-computed expectations.
module tb_pad_cfg_ctrl;

    localparam int NI = 12;
    localparam int NB = 40;
    localparam logic [NB-1:0] ALL_B = {NB{1'b1}};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid, cfg_ready, cfg_we;
    logic [5:0]    cfg_addr, cfg_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [5:0]    rsp_rdata;
    logic [NI-1:0] input_pu, input_pd, input_in, input_sync;
    logic [NB-1:0] bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
    logic [NB-1:0] bidir_in, bidir_sync;

    int            checks = 0;
    int            errors = 0;
    logic [5:0]    rd;
    logic          er;
    logic [NB-1:0] oe_at_accept;

    pad_cfg_ctrl #(.NUM_INPUT_PADS(NI), .NUM_BIDIR_PADS(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .input_pu(input_pu), .input_pd(input_pd),
        .bidir_oe(bidir_oe), .bidir_cs(bidir_cs), .bidir_sl(bidir_sl),
        .bidir_ie(bidir_ie), .bidir_pu(bidir_pu), .bidir_pd(bidir_pd),
        .input_in(input_in), .bidir_in(bidir_in),
        .input_sync(input_sync), .bidir_sync(bidir_sync)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full request/response; captures bidir_oe just after the acceptance edge.
    task automatic xact(input logic we, input logic [5:0] addr, input logic [5:0] wdata,
                        output logic [5:0] rdata, output logic err);
        int n;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_we = we; cfg_addr = addr; cfg_wdata = wdata;
        n = 0;
        while (!cfg_ready && n < 20) begin @(negedge clk); n++; end
        if (!cfg_ready) check("cfg_ready_timeout", 0, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        oe_at_accept = bidir_oe;
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        if (!rsp_valid) check("rsp_valid_timeout", 0, 1);
        rdata = rsp_rdata;
        err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_we = 1'b0; cfg_addr = 6'd0; cfg_wdata = 6'd0;
        rsp_ready = 1'b0; input_in = '0; bidir_in = '0;

        // Reset values while rst_n is low
        #12;
        check("rst_ie", bidir_ie, ALL_B);
        check("rst_oe", bidir_oe, 0);
        check("rst_cs_sl", {bidir_cs, bidir_sl}, 0);
        check("rst_pupd", {bidir_pu, bidir_pd, input_pu, input_pd}, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("rel_cfg_ready", cfg_ready, 1);
        check("rel_rsp_valid", rsp_valid, 0);

        // Shadow write then read-back, active unchanged until commit
        xact(1'b1, 6'd3, 6'b001111, rd, er);
        check("wr3_err", er, 0);
        xact(1'b0, 6'd3, 6'd0, rd, er);
        check("rd3_data", rd, 6'b001111);
        check("rd3_err", er, 0);
        check("oe_pre_commit", bidir_oe, 0);
        xact(1'b0, 6'd63, 6'd0, rd, er);
        check("dirty_set", rd, 6'b000001);
        xact(1'b1, 6'd63, 6'b101010, rd, er);
        check("commit_rdata", rd, 0);
        check("commit_err", er, 0);
        check("oe_after_edge", oe_at_accept, 40'h8);
        check("cs_commit", bidir_cs, 40'h8);
        check("sl_commit", bidir_sl, 40'h8);
        check("ie_commit", bidir_ie, ALL_B);
        xact(1'b0, 6'd63, 6'd0, rd, er);
        check("dirty_clear", rd, 0);
        check("idle_rdata", rsp_rdata, 0);

        // Pull-up and pull-down together is rejected
        xact(1'b1, 6'd5, 6'b110000, rd, er);
        check("wr5_conflict_err", er, 1);
        xact(1'b0, 6'd5, 6'd0, rd, er);
        check("rd5_reset_val", rd, 6'b001000);

        // Input pads store only pu/pd
        xact(1'b1, 6'd40, 6'b010000, rd, er);
        check("wr40_err", er, 0);
        xact(1'b1, 6'd41, 6'b101111, rd, er);
        xact(1'b0, 6'd40, 6'd0, rd, er);
        check("rd40", rd, 6'b010000);
        xact(1'b0, 6'd41, 6'd0, rd, er);
        check("rd41_masked", rd, 6'b100000);
        xact(1'b1, 6'd45, 6'b110000, rd, er);
        check("wr45_conflict_err", er, 1);
        check("input_pu_pre", input_pu, 0);
        xact(1'b1, 6'd63, 6'd0, rd, er);
        check("input_pu_commit", input_pu, 12'h001);
        check("input_pd_commit", input_pd, 12'h002);

        // Backpressure: held response, no second acceptance until handshake
        @(negedge clk);
        cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = 6'd3;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cfg_addr = 6'd40;
            check("bp_cfg_ready", cfg_ready, 0);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rdata", rsp_rdata, 6'b001111);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_after_hs_valid", rsp_valid, 0);
        check("bp_after_hs_ready", cfg_ready, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check("bp_second_valid", rsp_valid, 1);
        check("bp_second_rdata", rsp_rdata, 6'b010000);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_done", rsp_valid, 0);

        // Unmapped accesses
        xact(1'b1, 6'd60, 6'b000001, rd, er);
        check("wr60_err", er, 1);
        check("wr60_rdata", rd, 0);
        xact(1'b0, 6'd55, 6'd0, rd, er);
        check("rd55_err", er, 1);
        xact(1'b0, 6'd63, 6'd0, rd, er);
        check("unmapped_no_dirty", rd, 0);

        // Reset during RESP
        xact(1'b1, 6'd7, 6'b000001, rd, er);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 6'd9; cfg_wdata = 6'b000011;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check("mid_rsp_valid", rsp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rsp_valid", rsp_valid, 0);
        check("async_rdata", rsp_rdata, 0);
        check("async_cs", bidir_cs, 0);
        check("async_ie", bidir_ie, ALL_B);
        check("async_input_pu", input_pu, 0);
        @(negedge clk); rst_n = 1'b1;
        xact(1'b0, 6'd3, 6'd0, rd, er);
        check("post_rst_rd3", rd, 6'b001000);
        xact(1'b0, 6'd7, 6'd0, rd, er);
        check("post_rst_rd7", rd, 6'b001000);
        xact(1'b0, 6'd63, 6'd0, rd, er);
        check("post_rst_clean", rd, 0);

        // Input conditioning
        @(negedge clk);
        bidir_in[0] = 1'b1; input_in[2] = 1'b1;
`ifdef PAD_CFG_SYNC_EN
        #1;
        check("sync_0", bidir_sync[0], 0);
        @(posedge clk); #1;
        check("sync_1", bidir_sync[0], 0);
        @(posedge clk); #1;
        check("sync_2", bidir_sync[0], 1);
        check("sync_in2", input_sync, 12'h004);
`else
        #1;
        check("comb_bidir", bidir_sync, 40'h1);
        check("comb_input", input_sync, 12'h004);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
